// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: forwarding-mux encodings and
// the load-use stall FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding-source selection for one EX-stage operand; EX/MEM wins over MEM/WB
// because it holds the younger result.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic [REG_W-1:0] rs,
    input  logic             ex_mem_regWrite,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             mem_wb_regWrite,
    input  logic [REG_W-1:0] mem_wb_rd,
    output fwd_sel_t         sel
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    always_comb begin
        sel = FWD_REG;
        if (ex_mem_regWrite && ex_mem_rd != ZR && ex_mem_rd == rs) begin
            sel = FWD_MEM;
        end else if (mem_wb_regWrite && mem_wb_rd != ZR && mem_wb_rd == rs) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: per-operand forwarding, load-use stall FSM, branch flush.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int NSRC     = 3,
    parameter int ZERO_REG = 31,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NSRC-1:0][REG_W-1:0]  id_rs,
    input  logic [NSRC-1:0]             id_rs_used,
    input  logic [NSRC-1:0][REG_W-1:0]  id_ex_rs,
    input  logic                        id_ex_memRead,
    input  logic [REG_W-1:0]            id_ex_rd,
    input  logic                        ex_mem_regWrite,
    input  logic [REG_W-1:0]            ex_mem_rd,
    input  logic                        mem_wb_regWrite,
    input  logic [REG_W-1:0]            mem_wb_rd,
    input  logic                        branch_taken,
    output logic [NSRC-1:0][1:0]        fwd_sel,
    output logic                        stall,
    output logic                        bubble,
    output logic                        flush,
    output hz_state_t                   dbg_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
`endif
);

    localparam logic [REG_W-1:0] ZR         = REG_W'(ZERO_REG);
    localparam logic [2:0]       LAT_RELOAD = 3'(LOAD_LAT - 1);

    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_lat
        $error("LOAD_LAT must be in 1..7");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    hz_state_t  state;
    logic [2:0] cnt;
    logic       load_use;

    for (genvar g = 0; g < NSRC; g++) begin : g_fwd
        fwd_sel_t sel;
        fwd_select #(
            .REG_W   (REG_W),
            .ZERO_REG(ZERO_REG)
        ) u_fwd_select (
            .rs             (id_ex_rs[g]),
            .ex_mem_regWrite(ex_mem_regWrite),
            .ex_mem_rd      (ex_mem_rd),
            .mem_wb_regWrite(mem_wb_regWrite),
            .mem_wb_rd      (mem_wb_rd),
            .sel            (sel)
        );
        assign fwd_sel[g] = reset ? FWD_REG : sel;
    end

    always_comb begin
        load_use = 1'b0;
        if (id_ex_memRead && id_ex_rd != ZR) begin
            for (int i = 0; i < NSRC; i++) begin
                if (id_rs_used[i] && id_rs[i] == id_ex_rd) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // The IDLE-cycle stall must be combinational so the first dependent
    // instruction is held in the same cycle the load is seen in ID/EX.
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (!reset) begin
            if (branch_taken) begin
                flush = 1'b1;
            end else if (state == STALL || load_use) begin
                stall = 1'b1;
            end
        end
    end

    assign bubble    = stall;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (branch_taken) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_use && LOAD_LAT > 1) begin
                        state <= STALL;
                        cnt   <= LAT_RELOAD;
                    end
                end
                STALL: begin
                    if (cnt <= 3'd1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed and randomized bench for hazard_fwd_unit against a cycle-level model
// built from the forwarding, load-use and flush rules.
module tb_hazard_fwd_unit;
    import hazard_pkg::*;

    localparam int REG_W    = 5;
    localparam int NSRC     = 3;
    localparam int ZERO_REG = 31;
    localparam int LOAD_LAT = 3;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NSRC-1:0][REG_W-1:0] id_rs;
    logic [NSRC-1:0]            id_rs_used;
    logic [NSRC-1:0][REG_W-1:0] id_ex_rs;
    logic                       id_ex_memRead;
    logic [REG_W-1:0]           id_ex_rd;
    logic                       ex_mem_regWrite;
    logic [REG_W-1:0]           ex_mem_rd;
    logic                       mem_wb_regWrite;
    logic [REG_W-1:0]           mem_wb_rd;
    logic                       branch_taken;
    logic [NSRC-1:0][1:0]       fwd_sel;
    logic                       stall, bubble, flush;
    hz_state_t                  dbg_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]           stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int m_left   = 0;
    int m_scnt   = 0;
    int m_fcnt   = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(
        .REG_W   (REG_W),
        .NSRC    (NSRC),
        .ZERO_REG(ZERO_REG),
        .LOAD_LAT(LOAD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rs_used     (id_rs_used),
        .id_ex_rs       (id_ex_rs),
        .id_ex_memRead  (id_ex_memRead),
        .id_ex_rd       (id_ex_rd),
        .ex_mem_regWrite(ex_mem_regWrite),
        .ex_mem_rd      (ex_mem_rd),
        .mem_wb_regWrite(mem_wb_regWrite),
        .mem_wb_rd      (mem_wb_rd),
        .branch_taken   (branch_taken),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .bubble         (bubble),
        .flush          (flush),
        .dbg_state      (dbg_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Forwarding rule: the most recent writer of a non-zero register wins.
    function automatic logic [2*NSRC-1:0] ref_fwd();
        logic [2*NSRC-1:0] r;
        r = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ex_mem_regWrite && ex_mem_rd != ZERO_REG && ex_mem_rd == id_ex_rs[i])
                r[2*i +: 2] = 2'b10;
            else if (mem_wb_regWrite && mem_wb_rd != ZERO_REG && mem_wb_rd == id_ex_rs[i])
                r[2*i +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic logic ref_load_use();
        logic hit;
        hit = 1'b0;
        if (id_ex_memRead && id_ex_rd != ZERO_REG)
            for (int i = 0; i < NSRC; i++)
                if (id_rs_used[i] && id_rs[i] == id_ex_rd) hit = 1'b1;
        return hit;
    endfunction

    // Checks one clock cycle mid-period, then advances the model past the edge.
    task automatic cycle(input string tag);
        logic [2*NSRC-1:0] e_fwd;
        logic e_stall, e_flush, e_lu;
        int   e_state;
        #3;
        e_lu = ref_load_use();
        if (reset) begin
            e_fwd = '0; e_stall = 1'b0; e_flush = 1'b0; e_state = IDLE;
        end else begin
            e_fwd   = ref_fwd();
            e_flush = branch_taken;
            e_stall = !branch_taken && (m_left > 0 || e_lu);
            e_state = (m_left > 0) ? STALL : IDLE;
        end
        chk({tag, ".fwd"},    32'(fwd_sel), 32'(e_fwd));
        chk({tag, ".stall"},  32'(stall),   32'(e_stall));
        chk({tag, ".bubble"}, 32'(bubble),  32'(e_stall));
        chk({tag, ".flush"},  32'(flush),   32'(e_flush));
        chk({tag, ".state"},  32'(dbg_state), 32'(e_state));
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".scnt"}, 32'(stall_cnt), 32'(m_scnt));
        chk({tag, ".fcnt"}, 32'(flush_cnt), 32'(m_fcnt));
`endif
        @(posedge clk);
        if (reset) begin
            m_left = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (branch_taken)    m_left = 0;
            else if (m_left > 0) m_left--;
            else if (e_lu)       m_left = LOAD_LAT - 1;
            if (e_stall && m_scnt < CNT_MAX) m_scnt++;
            if (e_flush && m_fcnt < CNT_MAX) m_fcnt++;
        end
        #1;
    endtask

    task automatic quiet();
        id_rs = '0; id_rs_used = '0; id_ex_rs = '0; id_ex_memRead = 1'b0; id_ex_rd = '0;
        ex_mem_regWrite = 1'b0; ex_mem_rd = '0; mem_wb_regWrite = 1'b0; mem_wb_rd = '0;
        branch_taken = 1'b0;
    endtask

    task automatic load_use_x4();
        id_ex_memRead = 1'b1; id_ex_rd = 5'd4;
        id_rs = {5'd9, 5'd4, 5'd7}; id_rs_used = 3'b111;
    endtask

    function automatic logic [REG_W-1:0] rnd_reg();
        return ($urandom_range(0, 7) == 0) ? REG_W'(ZERO_REG) : REG_W'($urandom_range(0, 4));
    endfunction

    initial begin
        quiet();
        reset = 1'b1;
        // Forwarding matches present while in reset must still read as 00.
        id_ex_rs = {5'd3, 5'd2, 5'd1};
        ex_mem_regWrite = 1'b1; ex_mem_rd = 5'd2; load_use_x4();
        cycle("reset0");
        cycle("reset1");
        quiet();
        reset = 1'b0;
        cycle("post_reset");

        // Independent per-operand selection.
        id_ex_rs = {5'd3, 5'd2, 5'd1};
        ex_mem_regWrite = 1'b1; ex_mem_rd = 5'd2;
        mem_wb_regWrite = 1'b1; mem_wb_rd = 5'd1;
        #2 chk("fwd_mix", 32'(fwd_sel), 32'(6'b00_10_01));
        cycle("fwd_mix");

        // EX/MEM priority, then the zero register.
        id_ex_rs = {5'd0, 5'd0, 5'd5};
        ex_mem_rd = 5'd5; mem_wb_rd = 5'd5;
        #2 chk("fwd_prio", 32'(fwd_sel[0]), 32'(2'b10));
        cycle("fwd_prio");
        id_ex_rs = {5'd0, 5'd0, 5'd31};
        ex_mem_rd = 5'd31; mem_wb_rd = 5'd31;
        #2 chk("fwd_zero", 32'(fwd_sel[0]), 32'(2'b00));
        cycle("fwd_zero");
        quiet();

        // Load-use stall lasts exactly LOAD_LAT cycles.
        load_use_x4();
        for (int k = 0; k < LOAD_LAT; k++) begin
            #2 chk("lu_stall", 32'(stall), 32'd1);
            cycle("lu_stall");
        end
        id_ex_memRead = 1'b0;
        #2 chk("lu_done", 32'(stall), 32'd0);
        cycle("lu_done");

        // Unused operand and zero-register load never stall.
        load_use_x4(); id_rs_used = 3'b101;
        #2 chk("lu_unused", 32'(stall), 32'd0);
        cycle("lu_unused");
        load_use_x4(); id_ex_rd = 5'd31; id_rs = {5'd31, 5'd31, 5'd31};
        #2 chk("lu_zero", 32'(stall), 32'd0);
        cycle("lu_zero");
        quiet();

        // Branch in the second stall cycle wins.
        load_use_x4();
        cycle("br_stall1");
        branch_taken = 1'b1;
        #2 chk("br_flush", 32'(flush), 32'd1);
        chk("br_nostall", 32'(stall), 32'd0);
        cycle("br_flush");
        quiet();
        #2 chk("br_idle", 32'(dbg_state), 32'(IDLE));
        cycle("br_idle");

        // Reset mid-STALL clears outputs without waiting for a clock edge.
        load_use_x4();
        id_ex_rs = {5'd0, 5'd0, 5'd6}; ex_mem_regWrite = 1'b1; ex_mem_rd = 5'd6;
        cycle("rst_stall1");
        #2 reset = 1'b1;
        #1 chk("rst_async_stall", 32'(stall), 32'd0);
        chk("rst_async_bubble", 32'(bubble), 32'd0);
        chk("rst_async_flush", 32'(flush), 32'd0);
        chk("rst_async_fwd", 32'(fwd_sel), 32'd0);
        chk("rst_async_state", 32'(dbg_state), 32'(IDLE));
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_async_scnt", 32'(stall_cnt), 32'd0);
`endif
        m_left = 0; m_scnt = 0; m_fcnt = 0;
        @(posedge clk); #1;
        cycle("rst_hold");
        reset = 1'b0;
        quiet();
        cycle("rst_first");

        // Continuous load-use drives the stall counter into saturation.
        load_use_x4();
        for (int k = 0; k < CNT_MAX + 4; k++) cycle("sat");
`ifdef HAZARD_PERF_CNT_EN
        #2 chk("sat_hold", 32'(stall_cnt), 32'(CNT_MAX));
`endif
        quiet();
        cycle("sat_done");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NSRC; i++) begin
                id_rs[i]    = rnd_reg();
                id_ex_rs[i] = rnd_reg();
            end
            id_rs_used      = 3'($urandom_range(0, 7));
            id_ex_memRead   = 1'($urandom_range(0, 1));
            id_ex_rd        = rnd_reg();
            ex_mem_regWrite = 1'($urandom_range(0, 1));
            ex_mem_rd       = rnd_reg();
            mem_wb_regWrite = 1'($urandom_range(0, 1));
            mem_wb_rd       = rnd_reg();
            branch_taken    = ($urandom_range(0, 7) == 0);
            reset           = ($urandom_range(0, 49) == 0);
            cycle("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
